// File: rtl/bus_mux_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_mux_pipe_pkg
// Description : Bus source index constants shared by the bus multiplexer,
//               its encoder and anything that builds src_out_en vectors.
// Revision    : 1.0  initial release
// ============================================================================
package bus_mux_pipe_pkg;

   // General-purpose register file sources
   localparam int SRC_R0  = 0;
   localparam int SRC_R1  = 1;
   localparam int SRC_R2  = 2;
   localparam int SRC_R3  = 3;
   localparam int SRC_R4  = 4;
   localparam int SRC_R5  = 5;
   localparam int SRC_R6  = 6;
   localparam int SRC_R7  = 7;
   localparam int SRC_R8  = 8;
   localparam int SRC_R9  = 9;
   localparam int SRC_R10 = 10;
   localparam int SRC_R11 = 11;
   localparam int SRC_R12 = 12;
   localparam int SRC_R13 = 13;
   localparam int SRC_R14 = 14;
   localparam int SRC_R15 = 15;

   // Special registers
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHI    = 18;
   localparam int SRC_ZLO    = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_INPORT = 22;
   localparam int SRC_CSIGN  = 23;

   localparam int NUM_BUS_SRC = 24;

endpackage : bus_mux_pipe_pkg
`default_nettype wire

// File: rtl/bus_mux_pipe_encoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_prio_encoder
// Description : Combinational priority encoder for an expected-one-hot vector.
//               Reports the lowest set index, whether any bit is set, and
//               whether more than one bit is set.
// Revision    : 1.0  initial release
// ============================================================================
module onehot_prio_encoder #(
   parameter int N = 24,
   parameter int W = 5
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any,
   output logic         multi
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = W'(i);
         end
      end
   end

   assign any   = |vec;
   // Clearing the lowest set bit leaves something only if two or more were set
   assign multi = |(vec & (vec - N'(1)));

endmodule : onehot_prio_encoder
`default_nettype wire

// File: rtl/bus_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bus_mux_pipe
// Description : Registered CPU bus multiplexer driven by one-hot source
//               enables. Lowest enabled source wins; multi-driver cycles set
//               a sticky conflict flag and bump a saturating counter.
// Revision    : 1.0  initial release
// ============================================================================
module bus_mux_pipe
   import bus_mux_pipe_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int NUM_SRC      = NUM_BUS_SRC,
   parameter int SEL_W        = 5,
   parameter int CNT_W        = 8,
   parameter bit HOLD_ON_IDLE = 1'b1
) (
   input  logic                      clock,
   input  logic                      clear,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [NUM_SRC-1:0]        src_out_en,
   input  logic                      conflict_ack,
   output logic [DATA_W-1:0]         bus_out,
   output logic [SEL_W-1:0]          bus_sel,
   output logic                      bus_valid,
   output logic                      conflict,
   output logic [CNT_W-1:0]          conflict_count
);

   logic [SEL_W-1:0]  w_idx;
   logic              w_any;
   logic              w_multi;
   logic [DATA_W-1:0] w_selData;

   logic [DATA_W-1:0] r_busOut;
   logic [SEL_W-1:0]  r_busSel;
   logic              r_busValid;
   logic              r_conflict;
   logic [CNT_W-1:0]  r_conflictCount;

   onehot_prio_encoder #(
      .N (NUM_SRC),
      .W (SEL_W)
   ) u_encoder (
      .vec   (src_out_en),
      .idx   (w_idx),
      .any   (w_any),
      .multi (w_multi)
   );

   // Select the winning source slice; a compare-per-source mux keeps the
   // index from ever reaching past the last real source
   always_comb begin
      w_selData = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_idx == SEL_W'(i)) begin
            w_selData = src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Bus register: capture the winner, otherwise hold or zero the data
   always_ff @(posedge clock) begin
      if (clear) begin
         r_busOut   <= '0;
         r_busSel   <= '0;
         r_busValid <= 1'b0;
      end else if (w_any) begin
         r_busOut   <= w_selData;
         r_busSel   <= w_idx;
         r_busValid <= 1'b1;
      end else begin
         r_busValid <= 1'b0;
         if (!HOLD_ON_IDLE) begin
            r_busOut <= '0;
         end
      end
   end

   // Sticky conflict flag: a new conflict beats a simultaneous acknowledge
   always_ff @(posedge clock) begin
      if (clear) begin
         r_conflict <= 1'b0;
      end else if (w_multi) begin
         r_conflict <= 1'b1;
      end else if (conflict_ack) begin
         r_conflict <= 1'b0;
      end
   end

   // Conflict cycle counter, saturating at all-ones
   always_ff @(posedge clock) begin
      if (clear) begin
         r_conflictCount <= '0;
      end else if (w_multi && (r_conflictCount != {CNT_W{1'b1}})) begin
         r_conflictCount <= r_conflictCount + CNT_W'(1);
      end
   end

   assign bus_out        = r_busOut;
   assign bus_sel        = r_busSel;
   assign bus_valid      = r_busValid;
   assign conflict       = r_conflict;
   assign conflict_count = r_conflictCount;

endmodule : bus_mux_pipe
`default_nettype wire

// File: tb/tb_bus_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_mux_pipe
// Description : Self-checking bench for bus_mux_pipe. Two instances share
//               stimulus: A holds on idle with a 2-bit counter, B zeroes on
//               idle with an 8-bit counter. A behavioural model predicts both.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bus_mux_pipe;
   import bus_mux_pipe_pkg::*;

   localparam int DW = 32;
   localparam int NS = NUM_BUS_SRC;
   localparam int SW = 5;

   logic              clock = 1'b0;
   logic              clear;
   logic [NS*DW-1:0]  srcData;
   logic [NS-1:0]     srcEn;
   logic              ack;

   logic [DW-1:0] busOutA, busOutB;
   logic [SW-1:0] busSelA, busSelB;
   logic          validA, validB;
   logic          confA, confB;
   logic [1:0]    cntA;
   logic [7:0]    cntB;

   // Model state
   logic [DW-1:0] mOutA, mOutB;
   logic [SW-1:0] mSel;
   logic          mValid;
   logic          mConf;
   int            mCntA, mCntB;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   bus_mux_pipe #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .CNT_W(2), .HOLD_ON_IDLE(1'b1)) dutA (
      .clock(clock), .clear(clear), .src_data(srcData), .src_out_en(srcEn),
      .conflict_ack(ack), .bus_out(busOutA), .bus_sel(busSelA), .bus_valid(validA),
      .conflict(confA), .conflict_count(cntA)
   );

   bus_mux_pipe #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .CNT_W(8), .HOLD_ON_IDLE(1'b0)) dutB (
      .clock(clock), .clear(clear), .src_data(srcData), .src_out_en(srcEn),
      .conflict_ack(ack), .bus_out(busOutB), .bus_sel(busSelB), .bus_valid(validB),
      .conflict(confB), .conflict_count(cntB)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference behaviour for one rising edge, from the rules directly
   task automatic modelEdge();
      int lowest;
      int drivers;
      lowest  = -1;
      drivers = 0;
      for (int i = 0; i < NS; i++) begin
         if (srcEn[i]) begin
            drivers++;
            if (lowest < 0) lowest = i;
         end
      end
      if (clear) begin
         mOutA = '0; mOutB = '0; mSel = '0; mValid = 1'b0; mConf = 1'b0;
         mCntA = 0;  mCntB = 0;
      end else begin
         if (lowest >= 0) begin
            mOutA  = srcData[lowest*DW +: DW];
            mOutB  = mOutA;
            mSel   = SW'(lowest);
            mValid = 1'b1;
         end else begin
            mValid = 1'b0;
            mOutB  = '0;
         end
         if (drivers >= 2) begin
            mConf = 1'b1;
            if (mCntA < 3)   mCntA++;
            if (mCntB < 255) mCntB++;
         end else if (ack) begin
            mConf = 1'b0;
         end
      end
   endtask

   task automatic checkAll(input string tag);
      chk({tag, ".outA"},   busOutA, mOutA);
      chk({tag, ".outB"},   busOutB, mOutB);
      chk({tag, ".selA"},   32'(busSelA), 32'(mSel));
      chk({tag, ".selB"},   32'(busSelB), 32'(mSel));
      chk({tag, ".validA"}, 32'(validA), 32'(mValid));
      chk({tag, ".validB"}, 32'(validB), 32'(mValid));
      chk({tag, ".confA"},  32'(confA), 32'(mConf));
      chk({tag, ".confB"},  32'(confB), 32'(mConf));
      chk({tag, ".cntA"},   32'(cntA), 32'(mCntA));
      chk({tag, ".cntB"},   32'(cntB), 32'(mCntB));
   endtask

   // Apply inputs, clock once, predict and compare
   task automatic step(input string tag, input logic clr, input logic [NS-1:0] en, input logic ak);
      clear = clr;
      srcEn = en;
      ack   = ak;
      @(posedge clock);
      modelEdge();
      #1;
      checkAll(tag);
   endtask

   task automatic setSrc(input int k, input logic [DW-1:0] v);
      srcData[k*DW +: DW] = v;
   endtask

   initial begin
      logic [NS-1:0] en;
      int            satExp [5];
      satExp = '{1, 2, 3, 3, 3};
      clear = 1'b1; ack = 1'b0; srcEn = '0;
      for (int i = 0; i < NS; i++) srcData[i*DW +: DW] = $urandom;
      mOutA = '0; mOutB = '0; mSel = '0; mValid = 1'b0; mConf = 1'b0; mCntA = 0; mCntB = 0;
      @(negedge clock);

      // Reset held with random enables and acks
      step("rst0", 1'b1, NS'($urandom), 1'b1);
      step("rst1", 1'b1, NS'($urandom), 1'b0);
      chk("rst.outA.zero", busOutA, 32'h0);
      step("idle0", 1'b0, '0, 1'b0);
      chk("idle0.valid.zero", 32'(validA), 32'h0);

      // Single drivers
      setSrc(SRC_R3, 32'h8);
      step("r3", 1'b0, NS'(1) << SRC_R3, 1'b0);
      chk("r3.direct", busOutA, 32'h8);
      setSrc(SRC_HI, 32'h10000);
      step("hi", 1'b0, NS'(1) << SRC_HI, 1'b0);
      chk("hi.sel.direct", 32'(busSelA), 32'd16);

      // Idle hold versus idle zero
      setSrc(SRC_INPORT, 32'h400000);
      step("inport", 1'b0, NS'(1) << SRC_INPORT, 1'b0);
      step("hold", 1'b0, '0, 1'b0);
      chk("hold.outA.direct", busOutA, 32'h400000);
      chk("hold.outB.direct", busOutB, 32'h0);
      chk("hold.sel.direct", 32'(busSelA), 32'd22);

      // Conflict, then acknowledge
      setSrc(SRC_R5, 32'hA);
      setSrc(SRC_PC, 32'h100);
      step("conf", 1'b0, (NS'(1) << SRC_R5) | (NS'(1) << SRC_PC), 1'b0);
      chk("conf.out.direct", busOutA, 32'hA);
      chk("conf.cnt.direct", 32'(cntB), 32'd1);
      step("ack", 1'b0, '0, 1'b1);
      chk("ack.conf.direct", 32'(confA), 32'h0);
      step("ackset", 1'b0, NS'(3), 1'b1);
      chk("ackset.conf.direct", 32'(confA), 32'h1);
      chk("ackset.cnt.direct", 32'(cntB), 32'd2);

      // Source data change while enable stays high shows one cycle later
      setSrc(SRC_MDR, 32'h1234);
      step("mdr0", 1'b0, NS'(1) << SRC_MDR, 1'b0);
      setSrc(SRC_MDR, 32'h5678);
      step("mdr1", 1'b0, NS'(1) << SRC_MDR, 1'b0);

      // Saturation of the 2-bit counter, then clear
      step("satclr", 1'b1, '0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step("sat", 1'b0, NS'(3) << i, 1'b0);
         chk("sat.cntA.direct", 32'(cntA), 32'(satExp[i]));
      end
      step("satclr2", 1'b1, NS'(3), 1'b1);
      chk("satclr2.cntA.direct", 32'(cntA), 32'h0);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < NS; i++) srcData[i*DW +: DW] = $urandom;
         case ($urandom_range(0, 3))
            0:       en = '0;
            1:       en = NS'(1) << $urandom_range(0, NS - 1);
            2:       en = (NS'(1) << $urandom_range(0, NS - 1)) | (NS'(1) << $urandom_range(0, NS - 1));
            default: en = NS'($urandom);
         endcase
         step("rand", ($urandom_range(0, 29) == 0), en, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_bus_mux_pipe
`default_nettype wire
